// File: rtl/avalon_fast_serial_cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : avalon_fast_serial_cmd_pkg                              |
// | Brief    : Opcodes, response codes and parser states for the       |
// |            fast-serial command master.                             |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package avalon_fast_serial_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  localparam logic [7:0] RSP_WR   = 8'hA1;
  localparam logic [7:0] RSP_RD   = 8'hA2;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  // Longest response: status byte plus one 32-bit data word.
  localparam int RSP_W = 40;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR_HI = 4'd1,
    S_ADDR_LO = 4'd2,
    S_BE      = 4'd3,
    S_DATA    = 4'd4,
    S_BUS_WR  = 4'd5,
    S_BUS_RD  = 4'd6,
    S_RD_WAIT = 4'd7,
    S_RESP    = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/avalon_fast_serial_resp_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : avalon_fast_serial_resp_tx                              |
// | Brief    : Load-and-shift response sender, up to 5 bytes MSB       |
// |            first, valid/ready handshake on the byte side.          |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
import avalon_fast_serial_cmd_pkg::*;

module avalon_fast_serial_resp_tx (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [RSP_W-1:0] bytes_i,
  input  logic [2:0]       len_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             done_o
);

  logic [RSP_W-1:0] shift_q;
  logic [2:0]       cnt_q;
  logic             valid_q;

  // Current byte always sits in the top lane of the shift register.
  assign tx_data_o  = shift_q[RSP_W-1 -: 8];
  assign tx_valid_o = valid_q;
  assign done_o     = valid_q & tx_ready_i & (cnt_q == 3'd1);

  // Load a whole response, then shift one byte out per accepted handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      shift_q <= bytes_i;
      cnt_q   <= len_i;
      valid_q <= 1'b1;
    end else if (valid_q && tx_ready_i) begin
      if (cnt_q == 3'd1) begin
        valid_q <= 1'b0;
      end else begin
        shift_q <= {shift_q[RSP_W-9:0], 8'h00};
        cnt_q   <= cnt_q - 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/avalon_fast_serial_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : avalon_fast_serial_cmd_master                           |
// | Brief    : Byte-stream command parser driving single-word Avalon-MM|
// |            reads/writes, with a byte-stream response.              |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
import avalon_fast_serial_cmd_pkg::*;

module avalon_fast_serial_cmd_master #(
  parameter int ADDR_W         = 10,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic              avm_debugaccess,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        is_rd_q, is_rd_d;
  logic [15:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [2:0]  lat_q, lat_d;
  logic [31:0] to_q, to_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        cs_q;
  logic        rx_ready_q, rx_ready_d;

  logic             rsp_load;
  logic [RSP_W-1:0] rsp_bytes;
  logic [2:0]       rsp_len;
  logic             rsp_done;
  logic             rx_fire;
  logic             unused_addr_hi;

  assign rx_fire        = rx_valid & rx_ready_q;
  // Upper address bits beyond ADDR_W are received but deliberately dropped.
  assign unused_addr_hi = ^addr_q;

  assign rx_ready        = rx_ready_q;
  assign avm_address     = addr_q[ADDR_W-1:0];
  assign avm_byteenable  = be_q;
  assign avm_writedata   = wdata_q;
  assign avm_chipselect  = cs_q;
  assign avm_read        = rd_q;
  assign avm_write       = wr_q;
  assign avm_debugaccess = wr_q;

  // Parser, bus control and timeout: next-state and response loading.
  always_comb begin
    state_d   = state_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    bcnt_d    = bcnt_q;
    lat_d     = lat_q;
    to_d      = to_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    rsp_load  = 1'b0;
    rsp_bytes = {RSP_ERR, 32'h0};
    rsp_len   = 3'd1;
    case (state_q)
      S_IDLE: begin
        to_d = '0;
        if (rx_fire) begin
          if (rx_data == OP_WRITE) begin
            is_rd_d = 1'b0;
            state_d = S_ADDR_HI;
          end else if (rx_data == OP_READ) begin
            is_rd_d = 1'b1;
            state_d = S_ADDR_HI;
          end else begin
            rsp_load = 1'b1;
            state_d  = S_RESP;
          end
        end
      end
      S_ADDR_HI, S_ADDR_LO, S_BE, S_DATA: begin
        // A byte arriving on the expiry cycle takes priority over the abort.
        if (rx_fire) begin
          to_d = '0;
          if (state_q == S_ADDR_HI) begin
            addr_d[15:8] = rx_data;
            state_d      = S_ADDR_LO;
          end else if (state_q == S_ADDR_LO) begin
            addr_d[7:0] = rx_data;
            if (is_rd_q) begin
              be_d    = 4'hF;
              rd_d    = 1'b1;
              state_d = S_BUS_RD;
            end else begin
              state_d = S_BE;
            end
          end else if (state_q == S_BE) begin
            be_d    = rx_data[3:0];
            bcnt_d  = 2'd0;
            state_d = S_DATA;
          end else begin
            wdata_d = {wdata_q[23:0], rx_data};
            bcnt_d  = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              wr_d    = 1'b1;
              state_d = S_BUS_WR;
            end
          end
        end else if (TO_EN && (to_q == TO_LAST)) begin
          to_d     = '0;
          rsp_load = 1'b1;
          state_d  = S_RESP;
        end else begin
          to_d = to_q + 32'd1;
        end
      end
      S_BUS_WR: begin
        if (!avm_waitrequest) begin
          wr_d      = 1'b0;
          rsp_load  = 1'b1;
          rsp_bytes = {RSP_WR, 32'h0};
          state_d   = S_RESP;
        end
      end
      S_BUS_RD: begin
        if (!avm_waitrequest) begin
          rd_d    = 1'b0;
          lat_d   = 3'(READ_LATENCY - 1);
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (lat_q == 3'd0) begin
          rsp_load  = 1'b1;
          rsp_bytes = {RSP_RD, avm_readdata};
          rsp_len   = 3'd5;
          state_d   = S_RESP;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rx_ready is registered from the state we are about to enter.
  always_comb begin
    rx_ready_d = 1'b0;
    case (state_d)
      S_IDLE, S_ADDR_HI, S_ADDR_LO, S_BE, S_DATA: rx_ready_d = 1'b1;
      default:                                    rx_ready_d = 1'b0;
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      bcnt_q     <= '0;
      lat_q      <= '0;
      to_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cs_q       <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      bcnt_q     <= bcnt_d;
      lat_q      <= lat_d;
      to_q       <= to_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cs_q       <= rd_d | wr_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  avalon_fast_serial_resp_tx u_resp_tx (
    .clk        (clk),
    .rst        (reset),
    .load_i     (rsp_load),
    .bytes_i    (rsp_bytes),
    .len_i      (rsp_len),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .done_o     (rsp_done)
  );

endmodule
`default_nettype wire

// File: doc/avalon_fast_serial_cmd_master.md
Name: avalon_fast_serial_cmd_master

Overview:
- Avalon-MM master that turns a byte-stream command protocol into single-word Avalon reads and writes.
- Sits between the fast-serial byte receiver/transmitter and the on-chip memory slave (1024 x 32, byte-enabled, writes gated by debugaccess).
- Gives the host read/write access to on-chip memory over the serial link and returns a response byte stream.

Parameters:
- ADDR_W, 10, Avalon word-address width; received address is truncated to the low ADDR_W bits.
- READ_LATENCY, 1, fixed cycles from read acceptance to valid avm_readdata (1..7).
- TIMEOUT_CYCLES, 65535, idle cycles allowed between bytes of one command before it is aborted; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  command byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  master accepts a byte; transfer happens when rx_valid & rx_ready
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  downstream accepts a byte
- avm_address  out  ADDR_W  word address
- avm_byteenable  out  4  byte lanes
- avm_chipselect  out  1  asserted with avm_read or avm_write
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  32  write data
- avm_debugaccess  out  1  asserted together with avm_write (slave write enable requires it)
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall; tie 0 for the on-chip memory

Behaviour:
- Reset values: all outputs registered and 0. rx_ready goes to 1 on the first clk edge after reset deasserts (state IDLE).
- Command formats, all fields MSB first:
  - WRITE: 0x01, ADDR_HI, ADDR_LO, BE, D3, D2, D1, D0. Only BE[3:0] is used. Response: 0xA1.
  - READ: 0x02, ADDR_HI, ADDR_LO. Response: 0xA2, D3, D2, D1, D0.
  - Any other opcode: response 0xEE, then return to IDLE.
- States:
  - IDLE → OP_DECODE on a byte.
  - ADDR_HI → ADDR_LO.
  - ADDR_LO → BE (write) or BUS_RD (read).
  - BE → DATA.
  - DATA: 4 bytes counted 0..3, then BUS_WR.
  - BUS_WR → RESP.
  - BUS_RD → RD_WAIT → RESP.
  - RESP → IDLE after the last byte.
  - OP_DECODE is folded into the IDLE byte acceptance; no extra cycle.
- rx_ready is 1 only in IDLE, ADDR_HI, ADDR_LO, BE and DATA. It is 0 in BUS_*, RD_WAIT and RESP. No byte is dropped or buffered.
- BUS_WR:
  - Assert chipselect, write, debugaccess, address, byteenable and writedata.
  - Hold them all stable while avm_waitrequest=1.
  - Deassert on the cycle after acceptance (write & ~waitrequest).
- BUS_RD: assert chipselect and read with the address. Same hold/deassert rule as BUS_WR.
- RD_WAIT: a counter loads READ_LATENCY-1 at acceptance. Capture avm_readdata when the counter reaches 0, i.e. exactly READ_LATENCY cycles after acceptance.
- RESP:
  - Load tx_data and set tx_valid.
  - Hold tx_data and tx_valid stable until tx_ready.
  - Advance a byte index on each tx_valid & tx_ready.
  - Back-to-back bytes are allowed when tx_ready stays 1.
- Timeout:
  - Counter runs only in ADDR_HI..DATA and reloads on every accepted byte.
  - When it reaches TIMEOUT_CYCLES with no byte, abort: send 0xEE, then IDLE. No Avalon access is issued.
  - If a byte arrives in the same cycle the timeout would expire, the byte wins and the counter reloads.
- Address: {ADDR_HI, ADDR_LO}[ADDR_W-1:0]; the upper bits are ignored silently.
- At most one Avalon transaction is outstanding; avm_read and avm_write are never asserted together.
- Reset mid-operation aborts immediately: Avalon strobes and tx_valid drop asynchronously, and any partial command is discarded.

Decomposition:
- Package avalon_fast_serial_cmd_pkg holds:
  - opcode constants: OP_WRITE=0x01, OP_READ=0x02;
  - response constants: RSP_WR=0xA1, RSP_RD=0xA2, RSP_ERR=0xEE;
  - the state enum.
- One sub-module, avalon_fast_serial_resp_tx: a 5-byte load-and-shift response sender with valid/ready handshake. Command parsing and Avalon control stay in the top module.

Test Plan:
- Write then read: send 01 00 05 0F DE AD BE EF, then 02 00 05 → tx 0xA1; one write at address 5 with byteenable 0xF, data 0xDEADBEEF, debugaccess=1; then tx A2 DE AD BE EF, read data captured 1 cycle after acceptance.
- Partial byte enable: after the write above, send 01 00 05 02 00 00 55 00, then read address 5 → tx A2 DE AD 55 EF.
- Waitrequest stall: hold waitrequest=1 for 3 cycles during a read of address 0x3FF → address, read and chipselect stable for all 4 cycles; exactly one acceptance; correct data returned; ADDR_HI=0xFF truncates to 0x3FF.
- Bad opcode and tx backpressure: send 0x7E with tx_ready toggling 0/1 → single 0xEE; tx_data stable while tx_ready=0; no Avalon strobe.
- Timeout: TIMEOUT_CYCLES=16, send 01 00 then idle 20 cycles → 0xEE after 16 idle cycles, no write issued; a following 02 00 00 is processed normally.
- Reset mid-read: assert reset while in RD_WAIT → all outputs 0 asynchronously; rx_ready=1 one cycle after release; a new command succeeds.
